vga_controller: RTL and testbench



---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_pixel_clk_div.sv | 45 ++++
 rtl/vga_controller.sv | 148 ++++++++++++++
 tb/tb_vga_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 Hz timing for the VGA raster generator.
package vga_pkg;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_n;
    } sync_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int COORD_LIMIT = 1024;

    function automatic coord_t wrap_inc(input coord_t v, input coord_t last);
        return (v == last) ? '0 : v + coord_t'(1);
    endfunction

endpackage

// File: rtl/vga_pixel_clk_div.sv
// Divides the system clock into a one-clk pixel enable and a 50% duty DAC clock.
module pixel_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o,
    output logic pix_en_o,
    output logic vga_clk_o
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          pix_en_q;
    logic          vga_clk_q;
    logic          wrap;

    assign wrap = (div_cnt_q == LAST);

    always_comb begin
        div_cnt_d = wrap ? '0 : div_cnt_q + DW'(1);
    end

    // vga_clk follows the counter value it will hold after this edge, so it
    // is high exactly while div_cnt sits in the upper half of its range.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
            pix_en_q  <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_en_q  <= wrap;
            vga_clk_q <= (div_cnt_d >= HALF);
        end
    end

    assign tick_o    = wrap;
    assign pix_en_o  = pix_en_q;
    assign vga_clk_o = vga_clk_q;

endmodule

// File: rtl/vga_controller.sv
// Raster timing generator: pixel counters, sync/blank decode and line/frame pulses.
// Optional VGA_CTRL_ALIGN_EN delays hsync/vsync/blank_n by ALIGN_LAT pixel ticks.
module vga_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int CLK_DIV   = 2,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int ALIGN_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic       vga_clk,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       frame_start,
    output logic       line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT  = coord_t'(V_ACTIVE);
    localparam coord_t HS_BEG = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_BEG = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic  HS_ON     = (HSYNC_POL != 0);
    localparam logic  VS_ON     = (VSYNC_POL != 0);
    localparam sync_t SYNC_IDLE = '{hsync: !HS_ON, vsync: !VS_ON, blank_n: 1'b0};

    generate
        if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_total
            $error("vga_controller: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
            $error("vga_controller: CLK_DIV must be even and at least 2");
        end
        if (ALIGN_LAT < 1) begin : g_bad_lat
            $error("vga_controller: ALIGN_LAT must be at least 1");
        end
    endgenerate

    logic tick;

    pixel_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk_i     (clk),
        .rst_i     (rst),
        .tick_o    (tick),
        .pix_en_o  (pix_en),
        .vga_clk_o (vga_clk)
    );

    coord_t x_q, x_d;
    coord_t y_q, y_d;
    sync_t  dec_q, dec_d;
    logic   ls_q, ls_d;
    logic   fs_q, fs_d;
    sync_t  sync_out;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            x_d = wrap_inc(x_q, H_LAST);
            if (x_q == H_LAST) begin
                y_d = wrap_inc(y_q, V_LAST);
            end
        end
    end

    // Decode from the next coordinates so the registered sync/blank describe
    // the same pixel as the registered x/y.
    always_comb begin
        dec_d.hsync   = (x_d >= HS_BEG && x_d <= HS_END) ? HS_ON : !HS_ON;
        dec_d.vsync   = (y_d >= VS_BEG && y_d <= VS_END) ? VS_ON : !VS_ON;
        dec_d.blank_n = (x_d < H_ACT) && (y_d < V_ACT);
        ls_d          = tick && (x_d == '0);
        fs_d          = ls_d && (y_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= H_LAST;
            y_q   <= V_LAST;
            dec_q <= SYNC_IDLE;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
            if (tick) begin
                dec_q <= dec_d;
            end
        end
    end

`ifdef VGA_CTRL_ALIGN_EN
    sync_t align_q [ALIGN_LAT];

    // Delay line matches the colour stage's memory read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ALIGN_LAT; i++) begin
                align_q[i] <= SYNC_IDLE;
            end
        end else if (tick) begin
            align_q[0] <= dec_q;
            for (int i = 1; i < ALIGN_LAT; i++) begin
                align_q[i] <= align_q[i-1];
            end
        end
    end

    assign sync_out = align_q[ALIGN_LAT-1];
`else
    assign sync_out = dec_q;
`endif

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = sync_out.hsync;
    assign vsync       = sync_out.vsync;
    assign blank_n     = sync_out.blank_n;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: default-timing line vectors plus a reduced-timing,
// active-high-sync instance checked every clock across full frames.
module tb_vga_controller;

`ifdef VGA_CTRL_ALIGN_EN
    localparam int ALAT = 2;
`else
    localparam int ALAT = 0;
`endif
    localparam int LAT_PARAM = (ALAT == 0) ? 1 : ALAT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       pix_en, vga_clk, hsync, vsync, blank_n, frame_start, line_start;
    logic [9:0] x, y;

    logic       p_pix_en, p_vga_clk, p_hsync, p_vsync, p_blank_n, p_fs, p_ls;
    logic [9:0] p_x, p_y;

    always #5 clk = ~clk;

    vga_controller #(
        .ALIGN_LAT (LAT_PARAM)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .vga_clk     (vga_clk),
        .x           (x),
        .y           (y),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank_n     (blank_n),
        .frame_start (frame_start),
        .line_start  (line_start)
    );

    // Reduced 32x15 raster: hsync 20..27, vsync 10..11, visible 16x8.
    vga_controller #(
        .H_ACTIVE  (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE  (8),  .V_FP (2), .V_SYNC (2), .V_BP (3),
        .CLK_DIV   (2),
        .HSYNC_POL (1),
        .VSYNC_POL (1),
        .ALIGN_LAT (LAT_PARAM)
    ) u_pol (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (p_pix_en),
        .vga_clk     (p_vga_clk),
        .x           (p_x),
        .y           (p_y),
        .hsync       (p_hsync),
        .vsync       (p_vsync),
        .blank_n     (p_blank_n),
        .frame_start (p_fs),
        .line_start  (p_ls)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- default-timing vector table ----------------
    typedef struct {
        int         tick;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [4:0] flags;   // {hsync, vsync, blank_n, line_start, frame_start}
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    // ---------------- reduced-timing model ----------------
    int         clk_n;
    int         tick_n;
    int         vi;
    int         last_fs_tick;
    logic [9:0] mx, my;
    logic [2:0] dec_q[$];   // undelayed {hsync, vsync, blank_n}, oldest first

    task automatic reset_model();
        clk_n        = 0;
        tick_n       = 0;
        vi           = 0;
        last_fs_tick = 0;
        mx           = 10'd31;
        my           = 10'd14;
        dec_q.delete();
        for (int i = 0; i <= ALAT; i++) dec_q.push_back(3'b000);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_dut"}, 32'({x, y, hsync, vsync, blank_n, line_start, frame_start, pix_en, vga_clk}),
            32'({10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        chk({tag, "_pol"}, 32'({p_x, p_y, p_hsync, p_vsync, p_blank_n, p_ls, p_fs, p_pix_en, p_vga_clk}),
            32'({10'd31, 10'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    endtask

    task automatic run(input int n);
        logic       is_tick;
        logic       e_ls, e_fs;
        logic [2:0] e_dec;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clk_n++;
            is_tick = (clk_n % 2 == 0);
            chk("pix_en", 32'({pix_en, p_pix_en}), 32'({is_tick, is_tick}));
            chk("vga_clk", 32'({vga_clk, p_vga_clk}), 32'({~is_tick, ~is_tick}));
            if (is_tick) begin
                tick_n++;
                if (mx == 10'd31) begin
                    mx = 10'd0;
                    my = (my == 10'd14) ? 10'd0 : my + 10'd1;
                end else begin
                    mx = mx + 10'd1;
                end
                dec_q.push_back({(mx >= 10'd20 && mx <= 10'd27),
                                 (my >= 10'd10 && my <= 10'd11),
                                 (mx < 10'd16 && my < 10'd8)});
            end
            e_ls  = is_tick && (mx == 10'd0);
            e_fs  = e_ls && (my == 10'd0);
            e_dec = dec_q[tick_n];
            chk("pol_xy", 32'({p_x, p_y}), 32'({mx, my}));
            chk("pol_start", 32'({p_ls, p_fs}), 32'({e_ls, e_fs}));
            chk("pol_sync", 32'({p_hsync, p_vsync, p_blank_n}), 32'(e_dec));
            if (p_fs) begin
                if (last_fs_tick > 0) chk("frame_period", 32'(tick_n - last_fs_tick), 32'd480);
                last_fs_tick = tick_n;
            end
            if (!is_tick) chk("dut_start_idle", 32'({line_start, frame_start}), 32'd0);
            if (is_tick && vi < NV && tick_n == vecs[vi].tick) begin
                chk($sformatf("tbl%0d_x", vecs[vi].tick), 32'(x), 32'(vecs[vi].ex));
                chk($sformatf("tbl%0d_y", vecs[vi].tick), 32'(y), 32'(vecs[vi].ey));
                chk($sformatf("tbl%0d_start", vecs[vi].tick), 32'({line_start, frame_start}),
                    32'(vecs[vi].flags[1:0]));
`ifndef VGA_CTRL_ALIGN_EN
                chk($sformatf("tbl%0d_sync", vecs[vi].tick), 32'({hsync, vsync, blank_n}),
                    32'(vecs[vi].flags[4:2]));
`endif
                vi++;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{1,    10'd0,   10'd0, 5'b11111};
        vecs[1]  = '{2,    10'd1,   10'd0, 5'b11100};
        vecs[2]  = '{640,  10'd639, 10'd0, 5'b11100};
        vecs[3]  = '{641,  10'd640, 10'd0, 5'b11000};
        vecs[4]  = '{656,  10'd655, 10'd0, 5'b11000};
        vecs[5]  = '{657,  10'd656, 10'd0, 5'b01000};
        vecs[6]  = '{752,  10'd751, 10'd0, 5'b01000};
        vecs[7]  = '{753,  10'd752, 10'd0, 5'b11000};
        vecs[8]  = '{800,  10'd799, 10'd0, 5'b11000};
        vecs[9]  = '{801,  10'd0,   10'd1, 5'b11110};
        vecs[10] = '{802,  10'd1,   10'd1, 5'b11100};
        vecs[11] = '{1101, 10'd300, 10'd1, 5'b11100};

        // clock/reset
        rst = 1'b1;
        reset_model();
        repeat (3) @(negedge clk);
        check_reset("reset");
        #2 rst = 1'b0;

        // two reduced frames and the first default line and a bit
        run(2202);

        // asynchronous reset mid-line, between clock edges
        #3 rst = 1'b1;
        #1 check_reset("midreset");
        repeat (2) @(negedge clk);
        check_reset("reset_hold");
        #2 rst = 1'b0;
        reset_model();
        run(6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
